// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard-control inputs, instruction-memory port and the IF/ID
// register outputs. The master side is the fetch unit.
interface fetch_unit_if #(
   parameter int PC_WIDTH = 8
);
   logic                pc_stall;
   logic                mispredict;
   logic [PC_WIDTH-1:0] branch_target;
   logic [PC_WIDTH-1:0] imem_addr;
   logic [15:0]         imem_data;
   logic [15:0]         ifid_instr;
   logic [PC_WIDTH-1:0] ifid_pc1;
   logic                ifid_valid;
   logic                ifid_is_beq;
   logic                dbg_flush;

   // No ready/valid pair here: ifid_valid qualifies the IF/ID contents on every
   // cycle, and pc_stall/mispredict act as the back-pressure and kill controls.
   modport master (
      input  pc_stall, mispredict, branch_target, imem_data,
      output imem_addr, ifid_instr, ifid_pc1, ifid_valid, ifid_is_beq, dbg_flush
   );

   modport slave (
      output pc_stall, mispredict, branch_target, imem_data,
      input  imem_addr, ifid_instr, ifid_pc1, ifid_valid, ifid_is_beq, dbg_flush
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, stall hold and mispredict flush.
// Optional saturating stall/flush counters are built with FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter int                  PC_WIDTH    = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [15:0]         NOP_INSTR   = 16'h0000,
   parameter int                  FLUSH_DEPTH = 2
) (
   input  logic          clock,
   input  logic          reset,
   fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]   stall_count,
   output logic [15:0]   flush_count
`endif
);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   // The redirect edge is itself the first bubble, so the countdown starts at DEPTH-2.
   localparam logic [2:0] FCNT_INIT  = 3'((FLUSH_DEPTH > 1) ? (FLUSH_DEPTH - 2) : 0);
   localparam state_t     MISP_STATE = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_fcnt, w_fcnt_nxt;
   logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc;
   logic [15:0]         r_instr, w_instr_nxt;
   logic [PC_WIDTH-1:0] r_pc1, w_pc1_nxt;
   logic                r_valid, w_valid_nxt;
   logic                w_stall_edge;

   assign w_pc_inc = r_pc + PC_WIDTH'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_RUN;
         r_fcnt  <= 3'd0;
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_pc1   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
         r_pc1   <= w_pc1_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      if (bus.mispredict) begin
         w_state_nxt = MISP_STATE;
         w_fcnt_nxt  = FCNT_INIT;
      end else if (r_state == ST_FLUSH) begin
         if (r_fcnt == 3'd0) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_fcnt_nxt = r_fcnt - 3'd1;
         end
      end
   end

   always_comb begin
      w_pc_nxt     = r_pc;
      w_instr_nxt  = r_instr;
      w_pc1_nxt    = r_pc1;
      w_valid_nxt  = r_valid;
      w_stall_edge = 1'b0;
      if (bus.mispredict) begin
         w_pc_nxt    = bus.branch_target;
         w_instr_nxt = NOP_INSTR;
         w_valid_nxt = 1'b0;
      end else if (r_state == ST_FLUSH) begin
         // pc_stall has no effect while bubbles are still being inserted.
         w_instr_nxt = NOP_INSTR;
         w_valid_nxt = 1'b0;
      end else if (bus.pc_stall) begin
         w_stall_edge = 1'b1;
      end else begin
         w_pc_nxt    = w_pc_inc;
         w_instr_nxt = bus.imem_data;
         w_pc1_nxt   = w_pc_inc;
         w_valid_nxt = 1'b1;
      end
   end

   assign bus.imem_addr   = r_pc;
   assign bus.ifid_instr  = r_instr;
   assign bus.ifid_pc1    = r_pc1;
   assign bus.ifid_valid  = r_valid;
   assign bus.ifid_is_beq = r_valid && (r_instr[15:13] == 3'd2);
   assign bus.dbg_flush   = (r_state == ST_FLUSH);

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if (w_stall_edge && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
         if (bus.mispredict && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bubble-count model checked every cycle plus
// hand-computed expectations for reset, stall, flush, wrap and async reset.
module tb_fetch_unit;

   localparam int PC_W  = 8;
   localparam int DEPTH = 2;

   logic clock;
   logic reset;
   logic [15:0] rom [0:255];

   fetch_unit_if #(.PC_WIDTH(PC_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_count, flush_count;
`endif

   fetch_unit #(
      .PC_WIDTH   (PC_W),
      .RESET_PC   (8'h00),
      .NOP_INSTR  (16'h0000),
      .FLUSH_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_count(stall_count),
      .flush_count(flush_count)
`endif
   );

   assign bus.imem_data = rom[bus.imem_addr];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: PC, IF/ID fields and the number of bubble edges still owed.
   logic [7:0]  m_pc;
   logic [15:0] m_instr;
   logic [7:0]  m_pc1;
   logic        m_valid;
   int          m_bubbles;
   int          m_stalls;
   int          m_flushes;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pc = 8'h00; m_instr = 16'h0000; m_pc1 = 8'h00; m_valid = 1'b0;
         m_bubbles = 0; m_stalls = 0; m_flushes = 0;
      end else if (bus.mispredict) begin
         m_pc = bus.branch_target; m_instr = 16'h0000; m_valid = 1'b0;
         m_bubbles = DEPTH - 1;
         if (m_flushes < 65535) m_flushes++;
      end else if (m_bubbles > 0) begin
         m_instr = 16'h0000; m_valid = 1'b0;
         m_bubbles--;
      end else if (bus.pc_stall) begin
         if (m_stalls < 65535) m_stalls++;
      end else begin
         m_instr = rom[m_pc]; m_pc1 = m_pc + 8'd1; m_pc = m_pc + 8'd1; m_valid = 1'b1;
      end
   end

   always @(negedge clock) begin
      check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      check("ifid_instr", 32'(bus.ifid_instr), 32'(m_instr));
      check("ifid_pc1", 32'(bus.ifid_pc1), 32'(m_pc1));
      check("ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
      check("ifid_is_beq", 32'(bus.ifid_is_beq), 32'(m_valid && (m_instr[15:13] == 3'd2)));
      check("dbg_flush", 32'(bus.dbg_flush), 32'(m_bubbles > 0));
`ifdef FETCH_PERF_CNT_EN
      check("stall_count", 32'(stall_count), 32'(m_stalls));
      check("flush_count", 32'(flush_count), 32'(m_flushes));
`endif
   end

   task automatic step();
      @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
      rom[8'h41] = 16'h4ABC;
      reset = 1'b0;
      bus.pc_stall = 1'b0;
      bus.mispredict = 1'b0;
      bus.branch_target = 8'h00;

      step(); step();
      check("rst_addr", 32'(bus.imem_addr), 32'h0);
      check("rst_valid", 32'(bus.ifid_valid), 32'h0);
      check("rst_instr", 32'(bus.ifid_instr), 32'h0);
      check("rst_pc1", 32'(bus.ifid_pc1), 32'h0);
      reset = 1'b1;

      for (int k = 1; k <= 5; k++) begin
         step();
         check("seq_instr", 32'(bus.ifid_instr), 32'h1000 + 32'(k - 1));
         check("seq_pc1", 32'(bus.ifid_pc1), 32'(k));
         check("seq_valid", 32'(bus.ifid_valid), 32'h1);
      end

      bus.pc_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_addr", 32'(bus.imem_addr), 32'h5);
         check("stall_instr", 32'(bus.ifid_instr), 32'h1004);
      end
      bus.pc_stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt3", 32'(stall_count), 32'd3);
`endif
      step();
      check("post_stall", 32'(bus.ifid_instr), 32'h1005);

      bus.mispredict = 1'b1; bus.branch_target = 8'h40;
      step();
      bus.mispredict = 1'b0;
      check("redir_addr", 32'(bus.imem_addr), 32'h40);
      check("bub1_valid", 32'(bus.ifid_valid), 32'h0);
      check("bub1_pc1", 32'(bus.ifid_pc1), 32'h6);
      step();
      check("bub2_valid", 32'(bus.ifid_valid), 32'h0);
      check("bub2_instr", 32'(bus.ifid_instr), 32'h0);
      step();
      check("tgt_instr", 32'(bus.ifid_instr), 32'h1040);
      check("tgt_pc1", 32'(bus.ifid_pc1), 32'h41);
      check("tgt_valid", 32'(bus.ifid_valid), 32'h1);
      step();
      check("beq_flag", 32'(bus.ifid_is_beq), 32'h1);

      bus.mispredict = 1'b1; bus.branch_target = 8'h10;
      step();
      bus.branch_target = 8'h80; bus.pc_stall = 1'b1;
      step();
      bus.mispredict = 1'b0;
      check("re_addr", 32'(bus.imem_addr), 32'h80);
      check("re_valid", 32'(bus.ifid_valid), 32'h0);
      step();
      bus.pc_stall = 1'b0;
      check("re_bub", 32'(bus.ifid_valid), 32'h0);
      step();
      check("re_instr", 32'(bus.ifid_instr), 32'h1080);
      check("re_valid2", 32'(bus.ifid_valid), 32'h1);
`ifdef FETCH_PERF_CNT_EN
      check("flush_cnt", 32'(flush_count), 32'd3);
`endif

      bus.mispredict = 1'b1; bus.branch_target = 8'hFE;
      step();
      bus.mispredict = 1'b0;
      step(); step(); step();
      check("wrap_instr", 32'(bus.ifid_instr), 32'h10FF);
      check("wrap_pc1", 32'(bus.ifid_pc1), 32'h00);
      check("wrap_addr", 32'(bus.imem_addr), 32'h00);

      bus.mispredict = 1'b1; bus.branch_target = 8'h30;
      step();
      bus.mispredict = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("arst_addr", 32'(bus.imem_addr), 32'h0);
      check("arst_valid", 32'(bus.ifid_valid), 32'h0);
      check("arst_flush", 32'(bus.dbg_flush), 32'h0);
      step();
      reset = 1'b1;
      step();
      check("rel_instr", 32'(bus.ifid_instr), 32'h1000);
      check("rel_valid", 32'(bus.ifid_valid), 32'h1);
      step();
      check("rel_pc1", 32'(bus.ifid_pc1), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
